// File: rtl/pipe_ctrl.sv
`default_nettype none
//==============================================================================
// Module      : pipe_ctrl
// Description : Pipeline hazard / exception controller.
//               - Resolves per-stage stall requests into a freeze vector for
//                 the pc, the ifu and every pipe register: a request from
//                 stage k freezes stage k and every stage upstream of it.
//               - Sequences exception entry: accept, drain outstanding stalls,
//                 flush the youngest pipe registers, then hand the handler PC
//                 to the ifu with a valid/ready redirect handshake.
//               - Counts cycles in which the ifu is frozen (perf counter) and
//                 trips a sticky watchdog when the pipe stays frozen too long.
// Ports       : clk, rst            clock, synchronous active-high reset
//               stallreq_i          per-stage stall requests
//               excp_req_i/pc_i     exception request (level) and handler PC
//               excp_ack_o          one-cycle acceptance pulse
//               stall_o, flush_o    per-stage freeze, per-pipe-reg clear
//               redirect_*          PC redirect handshake towards the ifu
//               busy_o              exception sequence in progress
//               wdog_limit_i/hang_o watchdog threshold (0 = off), sticky trip
//               stall_cnt_o         cycles with stall_o[1] set (wrapping)
// Revision    : 1.0 - initial release
//==============================================================================
module pipe_ctrl #(
    parameter int NSTAGE     = 6,
    parameter int PC_W       = 32,
    parameter int EXCP_FLUSH = 2,
    parameter int FLUSH_CYC  = 1,
    parameter int WDOG_W     = 16,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NSTAGE-1:0] stallreq_i,
    input  logic              excp_req_i,
    input  logic [PC_W-1:0]   excp_pc_i,
    output logic              excp_ack_o,
    output logic [NSTAGE-1:0] stall_o,
    output logic [NSTAGE-3:0] flush_o,
    output logic              redirect_valid_o,
    output logic [PC_W-1:0]   redirect_pc_o,
    input  logic              redirect_ready_i,
    output logic              busy_o,
    input  logic [WDOG_W-1:0] wdog_limit_i,
    output logic              hang_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    // Exception sequencer states
    localparam logic [1:0] c_S_IDLE     = 2'd0;
    localparam logic [1:0] c_S_DRAIN    = 2'd1;
    localparam logic [1:0] c_S_FLUSH    = 2'd2;
    localparam logic [1:0] c_S_REDIRECT = 2'd3;

    // The flush down-counter only has to hold FLUSH_CYC-1
    localparam int c_FC_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam logic [c_FC_W-1:0] c_FC_LOAD = c_FC_W'(FLUSH_CYC - 1);
    localparam logic [c_FC_W-1:0] c_FC_ONE  = c_FC_W'(1);
    localparam logic [CNT_W-1:0]  c_CNT_ONE = CNT_W'(1);
    localparam logic [WDOG_W-1:0] c_WD_ONE  = WDOG_W'(1);

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic [PC_W-1:0]   r_pc;
    logic [c_FC_W-1:0] r_flush_cnt;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [WDOG_W-1:0] r_wdog_run;
    logic [WDOG_W-1:0] w_wdog_run_next;
    logic              r_hang;

    logic              w_accept;
    logic              w_load_fcnt;
    logic              w_busy;
    logic              w_in_flush;
    logic [NSTAGE-1:0] w_stall_req;
    logic [NSTAGE-1:0] w_stall;

    //--------------------------------------------------------------------------
    // Stall resolution: stage k is frozen when any stage at or below it in
    // the pipe (index >= k) asks for a stall, i.e. a suffix-OR of requests.
    //--------------------------------------------------------------------------
    generate
        for (genvar gk = 0; gk < NSTAGE; gk++) begin : g_stall_res
            assign w_stall_req[gk] = |stallreq_i[NSTAGE-1:gk];
        end
    endgenerate

    // While an exception is being sequenced the pc must not advance
    assign w_stall = w_stall_req | {{(NSTAGE-1){1'b0}}, w_busy};

    //--------------------------------------------------------------------------
    // Exception FSM: next-state and decoded outputs
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_load_fcnt  = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                // Accepted even with stalls pending; DRAIN waits them out
                if (excp_req_i) begin
                    w_accept     = 1'b1;
                    w_state_next = c_S_DRAIN;
                end
            end
            c_S_DRAIN: begin
                if (stallreq_i == '0) begin
                    w_load_fcnt  = 1'b1;
                    w_state_next = c_S_FLUSH;
                end
            end
            c_S_FLUSH: begin
                // Fixed length: new stall requests do not extend the flush
                if (r_flush_cnt == '0) begin
                    w_state_next = c_S_REDIRECT;
                end
            end
            c_S_REDIRECT: begin
                if (redirect_ready_i) begin
                    w_state_next = c_S_IDLE;
                end
            end
            default: begin
                w_state_next = c_S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_S_IDLE;
            r_pc        <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_pc <= excp_pc_i;
            end
            if (w_load_fcnt) begin
                r_flush_cnt <= c_FC_LOAD;
            end else if (w_in_flush && (r_flush_cnt != '0)) begin
                r_flush_cnt <= r_flush_cnt - c_FC_ONE;
            end
        end
    end

    assign w_busy     = (r_state != c_S_IDLE);
    assign w_in_flush = (r_state == c_S_FLUSH);

    // Flush only the youngest EXCP_FLUSH pipe registers; older ones retire
    generate
        for (genvar gi = 0; gi < NSTAGE - 2; gi++) begin : g_flush
            if (gi < EXCP_FLUSH) begin : g_flushed
                assign flush_o[gi] = w_in_flush;
            end else begin : g_kept
                assign flush_o[gi] = 1'b0;
            end
        end
    endgenerate

    // No acceptance while reset is applied: the PC would not be latched
    assign excp_ack_o       = w_accept & ~rst;
    assign stall_o          = w_stall;
    assign busy_o           = w_busy;
    assign redirect_valid_o = (r_state == c_S_REDIRECT);
    assign redirect_pc_o    = r_pc;

    //--------------------------------------------------------------------------
    // Perf counter and watchdog
    //--------------------------------------------------------------------------
    // Run length including the current cycle; the watchdog trips on the edge
    // that completes the limit-th consecutive stalled cycle.
    always_comb begin
        w_wdog_run_next = '0;
        if (w_stall != '0) begin
            if (r_wdog_run == '1) begin
                w_wdog_run_next = r_wdog_run;
            end else begin
                w_wdog_run_next = r_wdog_run + c_WD_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_wdog_run  <= '0;
            r_hang      <= 1'b0;
        end else begin
            if (w_stall[1]) begin
                r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
            end
            r_wdog_run <= w_wdog_run_next;
            if ((wdog_limit_i != '0) && (w_wdog_run_next == wdog_limit_i)) begin
                r_hang <= 1'b1;
            end
        end
    end

    assign hang_o      = r_hang;
    assign stall_cnt_o = r_stall_cnt;

endmodule
`default_nettype wire
